// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and widths for the fetch unit: FSM state encoding, instruction/PC widths and the
// default reset PC.
package pc_fetch_unit_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response and decode hand-off signals of the fetch unit.
// master = fetch unit side, slave = memory/decode environment side.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic              imem_req_valid;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst_data;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_sync_fifo.sv
// Small synchronous FIFO with same-cycle push/pop and a flush that empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == DEPTH_W);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: owns the PC, issues word-addressed imem reads under a credit limit, buffers in-order
// responses for decode and squashes stale ones after a redirect. PC_REDIRECT_STATS_EN adds counters.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [PC_W-1:0] target_address,
  pc_fetch_unit_if.master bus
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     drop_total
`endif
);

  localparam int unsigned   CW          = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] CREDITS_MAX = CW'(BUF_DEPTH);

  fetch_state_e           state_q, state_d;
  logic [PC_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]          credits_q, credits_d;
  logic [CW-1:0]          drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]          in_flight_q, in_flight_d;
  logic                   req_valid_q;

  logic                   accept, rsp, redir, inst_fire, drop, buf_push;
  logic [PC_W-1:0]        pc_rdata;
  logic                   pc_full, pc_empty, buf_full, buf_empty;
  logic [PC_W+INST_W-1:0] buf_rdata;

  assign accept    = req_valid_q & bus.imem_req_ready;
  assign rsp       = bus.imem_rsp_valid;
  assign redir     = pc_src & (state_q != StBoot);
  assign inst_fire = bus.inst_valid & bus.inst_ready;
  // A response arriving in the redirect cycle belongs to the old stream as well.
  assign drop      = rsp & (redir | (drop_cnt_q != '0));
  assign buf_push  = rsp & ~drop;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    in_flight_d = in_flight_q + CW'(accept) - CW'(rsp);
    credits_d   = credits_q;
    drop_cnt_d  = drop_cnt_q;
    state_d     = state_q;

    if (redir) begin
      fetch_pc_d = target_address;
      credits_d  = CREDITS_MAX - in_flight_d;
      drop_cnt_d = in_flight_d;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + 1'b1;
      credits_d  = credits_q - CW'(accept) + CW'(drop) + CW'(inst_fire);
      drop_cnt_d = drop_cnt_q - CW'(drop);
    end

    unique case (state_q)
      StBoot:  state_d = StFetch;
      default: state_d = (redir || (credits_d != '0)) ? StFetch : StHold;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      fetch_pc_q  <= RESET_PC;
      credits_q   <= CREDITS_MAX;
      drop_cnt_q  <= '0;
      in_flight_q <= '0;
      req_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      credits_q   <= credits_d;
      drop_cnt_q  <= drop_cnt_d;
      in_flight_q <= in_flight_d;
      req_valid_q <= (state_d == StFetch) && (credits_d != '0);
    end
  end

  fetch_sync_fifo #(
    .WIDTH (PC_W),
    .DEPTH (BUF_DEPTH)
  ) u_pc_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (1'b0),
    .push_i  (accept),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp),
    .rdata_o (pc_rdata),
    .full_o  (pc_full),
    .empty_o (pc_empty)
  );

  fetch_sync_fifo #(
    .WIDTH (PC_W + INST_W),
    .DEPTH (BUF_DEPTH)
  ) u_inst_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redir),
    .push_i  (buf_push),
    .wdata_i ({pc_rdata, bus.imem_rsp_data}),
    .pop_i   (inst_fire),
    .rdata_o (buf_rdata),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = ~buf_empty & ~pc_src;
  assign bus.inst_data      = buf_empty ? '0 : buf_rdata[INST_W-1:0];
  assign bus.inst_pc        = buf_empty ? '0 : buf_rdata[PC_W+INST_W-1:INST_W];

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt_q, drop_total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt_q <= '0;
      drop_total_q   <= '0;
    end else begin
      if (redir && (redirect_cnt_q != '1)) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (drop && (drop_total_q != '1))    drop_total_q   <= drop_total_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign drop_total   = drop_total_q;
`endif

`ifndef SYNTHESIS
  rsp_outstanding_a: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rsp_valid |-> !pc_empty);
  pc_fifo_room_a: assert property (@(posedge clk) disable iff (!rst_n) accept |-> !pc_full);
  buf_room_a: assert property (@(posedge clk) disable iff (!rst_n)
    (buf_push && !inst_fire) |-> !buf_full);
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: in-order memory model with fixed latency, decode sink and
// hand-computed expectations for sequencing, credit stall, redirect squash, PC wrap and reset.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  typedef struct packed {
    int              due;
    logic [PC_W-1:0] data;
  } mem_ent_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            pc_src = 1'b0;
  logic [PC_W-1:0] target_address = '0;

  pc_fetch_unit_if bus ();

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redirect_cnt, drop_total;
`endif

  pc_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_src         (pc_src),
    .target_address (target_address),
    .bus            (bus)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .drop_total     (drop_total)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  int          cyc;
  int          mem_lat;
  mem_ent_t    mem_q[$];
  logic [31:0] acc_log[$];
  logic [63:0] inst_log[$];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then drive the memory response for the new cycle.
  task automatic cycle();
    logic        acc, take, live;
    logic [31:0] addr;
    logic [63:0] ent;
    #1;
    live = rst_n;
    acc  = bus.imem_req_valid & bus.imem_req_ready;
    addr = bus.imem_req_addr;
    take = bus.inst_valid & bus.inst_ready;
    ent  = {bus.inst_pc, bus.inst_data};
    if (live && acc) mem_q.push_back('{due: cyc + mem_lat, data: mdata(addr)});
    @(posedge clk);
    #1;
    cyc++;
    if (live && acc) acc_log.push_back(addr);
    if (live && take) inst_log.push_back(ent);
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    pc_src             = 1'b0;
    target_address     = '0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b1;
    mem_q.delete();
    acc_log.delete();
    inst_log.delete();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic run_insts(input int n, input int budget, input string tag);
    int k = 0;
    while (inst_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check_eq(tag, inst_log.size(), n);
  endtask

  task automatic run_accs(input int n, input int budget, input string tag);
    int k = 0;
    while (acc_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check_eq(tag, acc_log.size(), n);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    pc_src         = 1'b1;
    target_address = tgt;
    cycle();
    pc_src         = 1'b0;
  endtask

  initial begin
    logic found;
    int   n;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    mem_lat = 1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_valid", bus.imem_req_valid, 0);
    check_eq("rst_req_addr", bus.imem_req_addr, 0);
    check_eq("rst_inst", {bus.inst_valid, bus.inst_pc, bus.inst_data}, 0);

    // Sequential fetch with 1-cycle memory and an always-ready decode.
    do_reset();
    check_eq("t1_boot_idle", bus.imem_req_valid, 0);
    cycle();
    check_eq("t1_first_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});
    cycle();
    check_eq("t1_addr1", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h1});
    check_eq("t1_no_inst_yet", bus.inst_valid, 0);
    cycle();
    check_eq("t1_latency", {bus.inst_valid, bus.inst_pc, bus.inst_data},
             {1'b1, 32'h0, 32'hDEAD_0000});
    check_eq("t1_credit_stall", bus.imem_req_valid, 0);
    run_insts(3, 20, "t1_count");
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t1_inst%0d", i), inst_log[i], {32'(i), mdata(32'(i))});
      check_eq($sformatf("t1_addr%0d", i), acc_log[i], 32'(i));
    end

    // Memory stall keeps the request stable; decode stall caps requests at the buffer depth.
    do_reset();
    bus.imem_req_ready = 1'b0;
    cycle();
    repeat (3) cycle();
    check_eq("t2_stall_acc", acc_log.size(), 0);
    check_eq("t2_stall_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h0});
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b0;
    repeat (10) cycle();
    check_eq("t2_acc_cnt", acc_log.size(), 2);
    check_eq("t2_hold", bus.imem_req_valid, 0);
    check_eq("t2_head", {bus.inst_valid, bus.inst_pc}, {1'b1, 32'h0});
    bus.inst_ready = 1'b1;
    run_accs(3, 20, "t2_resume_cnt");
    check_eq("t2_resume_addr", acc_log[2], 32'h2);
    run_insts(3, 20, "t2_inst_cnt");
    check_eq("t2_inst2", inst_log[2], {32'h2, mdata(32'h2)});

    // Redirect with two requests in flight: both responses are squashed.
    do_reset();
    mem_lat = 3;
    cycle();
    run_accs(2, 10, "t3_inflight");
    check_eq("t3_none_back", bus.imem_rsp_valid, 0);
    redirect(32'h40);
    run_insts(1, 30, "t3_first_cnt");
    check_eq("t3_first", inst_log[0], {32'h40, mdata(32'h40)});
    check_eq("t3_addr", acc_log[2], 32'h40);
    run_insts(3, 40, "t3_more_cnt");
    check_eq("t3_inst1", inst_log[1], {32'h41, mdata(32'h41)});
    check_eq("t3_inst2", inst_log[2], {32'h42, mdata(32'h42)});

    // Redirect in the cycle that accepts 0x5 while the response for 0x4 arrives.
    do_reset();
    mem_lat = 1;
    cycle();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h5 && bus.imem_rsp_valid) found = 1'b1;
      else cycle();
    end
    check_eq("t4_found", found, 1);
    redirect(32'h80);
    check_eq("t4_acc5", acc_log[5], 32'h5);
    n = inst_log.size();
    check_eq("t4_pre_cnt", n, 4);
    run_insts(5, 30, "t4_post_cnt");
    check_eq("t4_next_inst", inst_log[4], {32'h80, mdata(32'h80)});
    check_eq("t4_next_addr", acc_log[6], 32'h80);

    // PC wrap at the top of the address space; the request accepted with the redirect is dropped.
    do_reset();
    cycle();
    redirect(32'hFFFF_FFFF);
    check_eq("t5_acc_cnt", acc_log.size(), 1);
    run_insts(2, 30, "t5_inst_cnt");
    check_eq("t5_inst_top", inst_log[0], {32'hFFFF_FFFF, mdata(32'hFFFF_FFFF)});
    check_eq("t5_inst_wrap", inst_log[1], {32'h0, mdata(32'h0)});
    check_eq("t5_addr_top", acc_log[1], 32'hFFFF_FFFF);
    check_eq("t5_addr_wrap", acc_log[2], 32'h0);

    // Asynchronous reset while holding with a full buffer.
    do_reset();
    bus.inst_ready = 1'b0;
    cycle();
    repeat (8) cycle();
    check_eq("t6_full", {bus.inst_valid, bus.imem_req_valid}, {1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_req", {bus.imem_req_valid, bus.imem_req_addr}, 0);
    check_eq("t6_rst_inst", {bus.inst_valid, bus.inst_pc, bus.inst_data}, 0);
    do_reset();
    cycle();
    run_insts(2, 20, "t6_restart_cnt");
    check_eq("t6_restart_addr", acc_log[0], 32'h0);
    check_eq("t6_restart_inst", inst_log[0], {32'h0, mdata(32'h0)});

    // pc_src masks inst_valid, the decode handshake is ignored and the buffer is flushed.
    do_reset();
    bus.inst_ready = 1'b0;
    cycle();
    repeat (8) cycle();
    pc_src         = 1'b1;
    target_address = 32'h100;
    bus.inst_ready = 1'b1;
    #1;
    check_eq("t7_gate", bus.inst_valid, 0);
    cycle();
    pc_src = 1'b0;
    check_eq("t7_flushed", bus.inst_valid, 0);
    check_eq("t7_req", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 32'h100});
    run_insts(1, 20, "t7_cnt");
    check_eq("t7_inst", inst_log[0], {32'h100, mdata(32'h100)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
